// File: rtl/filter_step_seq.sv
// rtl/filter_step_seq.sv - step-level stimulus sequencer for a clocked filter model
// Drives v_in through a table of levels, samples v_out at the end of each step, flags range errors.
module filter_step_seq #(
    parameter int WIDTH      = 18,
    parameter int NUM_STEPS  = 4,
    parameter int SETTLE_CYC = 2,
    parameter int HOLD_CYC   = 64,
    parameter int LIMIT      = 24576,
    localparam int IDX_W     = (NUM_STEPS > 1) ? $clog2(NUM_STEPS) : 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    lvl_wr,
    input  logic [IDX_W-1:0]        lvl_addr,
    input  logic signed [WIDTH-1:0] lvl_data,
    output logic                    filt_rst,
    output logic signed [WIDTH-1:0] v_in,
    input  logic signed [WIDTH-1:0] v_out,
    output logic                    sample_valid,
    output logic signed [WIDTH-1:0] sample_data,
    output logic [IDX_W-1:0]        sample_idx,
    output logic                    busy,
    output logic                    done,
    output logic                    range_err
);

    localparam int CNT_MAX = (SETTLE_CYC > HOLD_CYC) ? SETTLE_CYC : HOLD_CYC;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam logic [WIDTH:0] LIMIT_M = (WIDTH+1)'(LIMIT);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_RST_FILT = 2'd1,
        S_STEP     = 2'd2,
        S_DONE     = 2'd3
    } state_t;

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic signed [WIDTH-1:0] table_q [NUM_STEPS];

    logic                    filt_rst_q, filt_rst_d;
    logic signed [WIDTH-1:0] v_in_q, v_in_d;
    logic                    sample_valid_q, sample_valid_d;
    logic signed [WIDTH-1:0] sample_data_q, sample_data_d;
    logic [IDX_W-1:0]        sample_idx_q, sample_idx_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic                    range_err_q, range_err_d;

    logic                    hold_end;
    logic                    wr_ok;
    logic signed [WIDTH:0]   v_ext;
    logic [WIDTH:0]          v_mag;
    logic                    over_limit;

    assign hold_end = (state_q == S_STEP) && (cnt_q == CNT_W'(HOLD_CYC - 1));
    assign wr_ok    = lvl_wr && (state_q == S_IDLE) &&
                      ({1'b0, lvl_addr} < (IDX_W+1)'(NUM_STEPS));

    // One extra bit so that negating the most negative code cannot wrap.
    assign v_ext      = {v_out[WIDTH-1], v_out};
    assign v_mag      = v_out[WIDTH-1] ? (~v_ext + 1'b1) : v_ext;
    assign over_limit = (v_mag > LIMIT_M);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_RST_FILT;
                    cnt_d   = '0;
                end
            end
            S_RST_FILT: begin
                if (cnt_q == CNT_W'(SETTLE_CYC - 1)) begin
                    state_d = S_STEP;
                    cnt_d   = '0;
                    idx_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_STEP: begin
                if (hold_end) begin
                    cnt_d = '0;
                    if (idx_q == IDX_W'(NUM_STEPS - 1)) begin
                        state_d = S_DONE;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs are derived from the next state so that they line up with it once registered.
    always_comb begin
        filt_rst_d     = (state_d == S_RST_FILT);
        v_in_d         = (state_d == S_STEP) ? table_q[idx_d] : '0;
        busy_d         = (state_d != S_IDLE);
        done_d         = (state_d == S_DONE);
        sample_valid_d = hold_end;
        sample_data_d  = hold_end ? v_out : sample_data_q;
        sample_idx_d   = hold_end ? idx_q : sample_idx_q;
        range_err_d    = range_err_q;
        if ((state_q == S_IDLE) && start) begin
            range_err_d = 1'b0;
        end else if ((state_q == S_STEP) && over_limit) begin
            range_err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            filt_rst_q     <= 1'b1;
            v_in_q         <= '0;
            sample_valid_q <= 1'b0;
            sample_data_q  <= '0;
            sample_idx_q   <= '0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            range_err_q    <= 1'b0;
        end else begin
            filt_rst_q     <= filt_rst_d;
            v_in_q         <= v_in_d;
            sample_valid_q <= sample_valid_d;
            sample_data_q  <= sample_data_d;
            sample_idx_q   <= sample_idx_d;
            busy_q         <= busy_d;
            done_q         <= done_d;
            range_err_q    <= range_err_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_STEPS; i++) begin
                table_q[i] <= '0;
            end
        end else if (wr_ok) begin
            table_q[lvl_addr] <= lvl_data;
        end
    end

    assign filt_rst     = filt_rst_q;
    assign v_in         = v_in_q;
    assign sample_valid = sample_valid_q;
    assign sample_data  = sample_data_q;
    assign sample_idx   = sample_idx_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign range_err    = range_err_q;

endmodule

// File: tb/tb_filter_step_seq.sv
// tb/tb_filter_step_seq.sv - directed self-checking bench for filter_step_seq
module tb_filter_step_seq;

    localparam int W   = 18;
    localparam int NS  = 4;
    localparam int SC  = 2;
    localparam int HC  = 8;
    localparam int LIM = 24576;

    logic clk = 1'b0;
    logic rst = 1'b0;

    logic                start = 1'b0;
    logic                lvl_wr = 1'b0;
    logic [1:0]          lvl_addr = '0;
    logic signed [W-1:0] lvl_data = '0;
    logic                filt_rst;
    logic signed [W-1:0] v_in;
    logic signed [W-1:0] v_out;
    logic                sample_valid;
    logic signed [W-1:0] sample_data;
    logic [1:0]          sample_idx;
    logic                busy, done, range_err;

    logic                d2_start = 1'b0;
    logic                d2_wr = 1'b0;
    logic [0:0]          d2_addr = '0;
    logic signed [W-1:0] d2_data = '0;
    logic                d2_frst;
    logic signed [W-1:0] d2_vin;
    logic signed [W-1:0] d2_vout;
    logic                d2_sv;
    logic signed [W-1:0] d2_sd;
    logic [0:0]          d2_si;
    logic                d2_busy, d2_done, d2_rerr;

    logic                force_en = 1'b0;
    logic signed [W-1:0] force_v = '0;
    int                  y_m = 0;
    int                  cyc = 0;

    int n_cmp = 0;
    int n_bad = 0;

    int start_cyc, nsamp, done_rel, frst_cnt, rerr_r0, rerr_mid, rerr_done, busy_done, busy_after;
    int s_rel[8];
    int s_idx[8];
    int s_data[8];
    int vin_at[4];
    int exp_tbl[4];

    filter_step_seq #(
        .WIDTH(W), .NUM_STEPS(NS), .SETTLE_CYC(SC), .HOLD_CYC(HC), .LIMIT(LIM)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .lvl_wr(lvl_wr), .lvl_addr(lvl_addr),
        .lvl_data(lvl_data), .filt_rst(filt_rst), .v_in(v_in), .v_out(v_out),
        .sample_valid(sample_valid), .sample_data(sample_data), .sample_idx(sample_idx),
        .busy(busy), .done(done), .range_err(range_err)
    );

    filter_step_seq #(
        .WIDTH(W), .NUM_STEPS(1), .SETTLE_CYC(SC), .HOLD_CYC(HC), .LIMIT(LIM)
    ) dut1 (
        .clk(clk), .rst(rst), .start(d2_start), .lvl_wr(d2_wr), .lvl_addr(d2_addr),
        .lvl_data(d2_data), .filt_rst(d2_frst), .v_in(d2_vin), .v_out(d2_vout),
        .sample_valid(d2_sv), .sample_data(d2_sd), .sample_idx(d2_si),
        .busy(d2_busy), .done(d2_done), .range_err(d2_rerr)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // First-order filter model: y += (x - y) >> 2
    always @(posedge clk) begin
        if (filt_rst) y_m <= 0;
        else          y_m <= y_m + ((int'(v_in) - y_m) >>> 2);
    end

    assign v_out   = force_en ? force_v : W'(y_m);
    assign d2_vout = W'(1234);

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int exp_sample(input int k);
        int y = 0;
        for (int s = 0; s <= k; s++) begin
            for (int n = 0; n < ((s == k) ? HC - 1 : HC); n++) begin
                y = y + ((exp_tbl[s] - y) >>> 2);
            end
        end
        return y;
    endfunction

    task automatic write_lvl(input int addr, input int data);
        @(negedge clk);
        lvl_wr = 1'b1; lvl_addr = 2'(addr); lvl_data = W'(data);
        @(negedge clk);
        lvl_wr = 1'b0;
    endtask

    task automatic run_seq(input bit perturb, input int frc_lo, input int frc_hi, input int frc_val,
                           input bit wr_en, input int wr_addr, input int wr_data);
        int rel;
        @(negedge clk);
        start = 1'b1; lvl_wr = wr_en; lvl_addr = 2'(wr_addr); lvl_data = W'(wr_data);
        @(posedge clk);
        #1 start_cyc = cyc;
        nsamp = 0; done_rel = -1; frst_cnt = 0;
        rerr_r0 = -1; rerr_mid = -1; rerr_done = -1; busy_done = -1;
        for (int s = 0; s < 4; s++) vin_at[s] = -1;
        @(negedge clk);
        start = 1'b0; lvl_wr = 1'b0;
        for (int k = 0; k < 80; k++) begin
            rel = cyc - start_cyc;
            if (filt_rst) frst_cnt++;
            if (sample_valid && nsamp < 8) begin
                s_rel[nsamp] = rel; s_idx[nsamp] = int'(sample_idx); s_data[nsamp] = int'(sample_data);
                nsamp++;
            end
            if (rel >= 2 && ((rel - 2) % HC) == 0 && ((rel - 2) / HC) < NS)
                vin_at[(rel - 2) / HC] = int'(v_in);
            if (rel == 0)  rerr_r0 = int'(range_err);
            if (rel == 12) rerr_mid = int'(range_err);
            force_en = (rel >= frc_lo) && (rel < frc_hi);
            force_v  = W'(frc_val);
            if (perturb) begin
                start = (rel == 12); lvl_wr = (rel == 12); lvl_addr = 2'd0; lvl_data = W'(999);
            end
            if (done) begin
                done_rel = rel; rerr_done = int'(range_err); busy_done = int'(busy);
                break;
            end
            @(negedge clk);
        end
        start = 1'b0; lvl_wr = 1'b0; force_en = 1'b0;
        @(negedge clk);
        busy_after = int'(busy);
    endtask

    task automatic check_run(input string nm);
        chk({nm, ".done_rel"}, done_rel, SC + NS * HC);
        chk({nm, ".nsamp"}, nsamp, NS);
        chk({nm, ".frst_cycles"}, frst_cnt, SC);
        chk({nm, ".busy_at_done"}, busy_done, 1);
        chk({nm, ".busy_after"}, busy_after, 0);
        chk({nm, ".range_err"}, rerr_done, 0);
        for (int s = 0; s < NS; s++) begin
            chk($sformatf("%s.s%0d_rel", nm, s), s_rel[s], SC + HC * (s + 1));
            chk($sformatf("%s.s%0d_idx", nm, s), s_idx[s], s);
            chk($sformatf("%s.s%0d_data", nm, s), s_data[s], exp_sample(s));
            chk($sformatf("%s.vin%0d", nm, s), vin_at[s], exp_tbl[s]);
        end
    endtask

    initial begin
        int rel, v2a, v2b, srel, sidx, sdat, drel;

        #1 rst = 1'b1;
        #1;
        chk("rst.filt_rst", filt_rst, 1);
        chk("rst.v_in", v_in, 0);
        chk("rst.busy", busy, 0);
        chk("rst.done", done, 0);
        chk("rst.sample_valid", sample_valid, 0);
        chk("rst.range_err", range_err, 0);
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("idle.filt_rst", filt_rst, 0);

        // 1: basic run
        exp_tbl = '{16384, 0, -16384, 8192};
        for (int a = 0; a < NS; a++) write_lvl(a, exp_tbl[a]);
        run_seq(1'b0, -1, -1, 0, 1'b0, 0, 0);
        check_run("s1");
        chk("s1.s0_hand", s_data[0], 14197);

        // 3: start and lvl_wr pulses while busy
        run_seq(1'b1, -1, -1, 0, 1'b0, 0, 0);
        check_run("s3");

        // 2: range error sticky, cleared by next start
        run_seq(1'b0, 10, 17, 24577, 1'b0, 0, 0);
        chk("s2.rerr_step1", rerr_mid, 1);
        chk("s2.rerr_done", rerr_done, 1);
        chk("s2.done_rel", done_rel, SC + NS * HC);
        run_seq(1'b0, -1, -1, 0, 1'b0, 0, 0);
        chk("s2.rerr_cleared", rerr_r0, 0);
        check_run("s2clr");
        run_seq(1'b0, 10, 17, -131072, 1'b0, 0, 0);
        chk("s2.rerr_neg", rerr_done, 1);
        run_seq(1'b0, 10, 17, -24576, 1'b0, 0, 0);
        chk("s2.rerr_at_limit", rerr_done, 0);

        // 4: reset mid-run
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start_cyc = cyc;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < 40 && (cyc - start_cyc) < 15; k++) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("s4.filt_rst", filt_rst, 1);
        chk("s4.busy", busy, 0);
        chk("s4.done", done, 0);
        chk("s4.sample_valid", sample_valid, 0);
        chk("s4.v_in", v_in, 0);
        @(negedge clk);
        rst = 1'b0;
        exp_tbl = '{0, 0, 0, 0};
        run_seq(1'b0, -1, -1, 0, 1'b0, 0, 0);
        check_run("s4");

        // 5: write and start in the same cycle
        exp_tbl = '{0, 0, -8192, 0};
        run_seq(1'b0, -1, -1, 0, 1'b1, 2, -8192);
        check_run("s5");

        // Single-step instance; write to addr 1 is out of range
        @(negedge clk);
        d2_wr = 1'b1; d2_addr = 1'b0; d2_data = W'(4000);
        @(negedge clk);
        d2_addr = 1'b1; d2_data = W'(7000);
        @(negedge clk);
        d2_wr = 1'b0; d2_start = 1'b1;
        @(posedge clk);
        #1 start_cyc = cyc;
        @(negedge clk);
        d2_start = 1'b0;
        v2a = -1; v2b = -1; srel = -1; sidx = -1; sdat = -1; drel = -1;
        for (int k = 0; k < 40; k++) begin
            rel = cyc - start_cyc;
            if (rel == 2) v2a = int'(d2_vin);
            if (rel == 9) v2b = int'(d2_vin);
            if (d2_sv) begin srel = rel; sidx = int'(d2_si); sdat = int'(d2_sd); end
            if (d2_done) begin drel = rel; break; end
            @(negedge clk);
        end
        chk("n1.vin_first", v2a, 4000);
        chk("n1.vin_last", v2b, 4000);
        chk("n1.done_rel", drel, SC + HC);
        chk("n1.sample_rel", srel, SC + HC);
        chk("n1.sample_idx", sidx, 0);
        chk("n1.sample_data", sdat, 1234);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
